change_dispenser_fsm: RTL

- Parametrised successor to the vending-machine change FSM. It takes a money/price pair on a start pulse and computes the change.
- Change is dispensed greedily, one coin per cycle, on four coin strobes.
- Adds per-coin inventory tracking with refill, an insufficient-funds error and a cannot-make-change error.
- Sits between the vending-machine controller (which supplies money, price and start) and the coin-hopper drivers.

---
 rtl/change_dispenser_fsm.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/change_dispenser_fsm.sv
// Change dispenser: latches money/price, then pays out change greedily one coin per cycle
// from per-denomination inventories, flagging insufficient funds or unmakeable change.
module change_dispenser_fsm #(
    parameter int unsigned           WIDTH    = 7,
    parameter int unsigned           INV_W    = 4,
    parameter logic [INV_W-1:0]      INV_INIT = INV_W'(8),
    parameter int unsigned           DEN_Q    = 25,
    parameter int unsigned           DEN_D    = 10,
    parameter int unsigned           DEN_N    = 5,
    parameter int unsigned           DEN_P    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] money,
    input  logic [WIDTH-1:0] price,
    input  logic             inv_load,
    input  logic [INV_W-1:0] inv_q,
    input  logic [INV_W-1:0] inv_d,
    input  logic [INV_W-1:0] inv_n,
    input  logic [INV_W-1:0] inv_p,
    output logic             disp_Q,
    output logic             disp_D,
    output logic             disp_N,
    output logic             disp_P,
    output logic             done,
    output logic             busy,
    output logic             err_funds,
    output logic             err_nochange,
    output logic [WIDTH-1:0] change_left,
    output logic [3:0]       inv_empty
);

    typedef enum logic [1:0] {StIdle, StCalc, StDisp, StDone} state_t;

    // Index 3..0 = Q, D, N, P throughout, matching inv_empty bit order.
    localparam logic [WIDTH-1:0] DEN [4] = '{WIDTH'(DEN_P), WIDTH'(DEN_N),
                                             WIDTH'(DEN_D), WIDTH'(DEN_Q)};

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   money_q, money_d;
    logic [WIDTH-1:0]   price_q, price_d;
    logic [WIDTH-1:0]   change_q, change_d;
    logic [INV_W-1:0]   cnt_q [4];
    logic [INV_W-1:0]   cnt_d [4];
    logic [3:0]         disp_q, disp_d;
    logic               done_q, done_d;
    logic               efunds_q, efunds_d;
    logic               enoch_q, enoch_d;
    logic               found;
    logic [1:0]         sel;

    always_comb begin
        state_d  = state_q;
        money_d  = money_q;
        price_d  = price_q;
        change_d = change_q;
        cnt_d    = cnt_q;
        disp_d   = '0;
        done_d   = 1'b0;
        efunds_d = efunds_q;
        enoch_d  = enoch_q;
        found    = 1'b0;
        sel      = 2'd0;

        // Largest affordable coin still in stock, Q first.
        for (int i = 3; i >= 0; i--) begin
            if (!found && cnt_q[i] != '0 && DEN[i] <= change_q) begin
                found = 1'b1;
                sel   = 2'(i);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (inv_load) cnt_d = '{inv_p, inv_n, inv_d, inv_q};
                if (start) begin
                    money_d  = money;
                    price_d  = price;
                    efunds_d = 1'b0;
                    enoch_d  = 1'b0;
                    change_d = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (money_q < price_q) begin
                    efunds_d = 1'b1;
                    change_d = '0;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    change_d = money_q - price_q;
                    state_d  = StDisp;
                end
            end
            StDisp: begin
                if (change_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else if (found) begin
                    disp_d[sel] = 1'b1;
                    change_d    = change_q - DEN[sel];
                    cnt_d[sel]  = cnt_q[sel] - INV_W'(1);
                end else begin
                    enoch_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            money_q  <= '0;
            price_q  <= '0;
            change_q <= '0;
            cnt_q    <= '{default: INV_INIT};
            disp_q   <= '0;
            done_q   <= 1'b0;
            efunds_q <= 1'b0;
            enoch_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            money_q  <= money_d;
            price_q  <= price_d;
            change_q <= change_d;
            cnt_q    <= cnt_d;
            disp_q   <= disp_d;
            done_q   <= done_d;
            efunds_q <= efunds_d;
            enoch_q  <= enoch_d;
        end
    end

    assign {disp_Q, disp_D, disp_N, disp_P} = disp_q;
    assign done         = done_q;
    assign busy         = (state_q != StIdle);
    assign err_funds    = efunds_q;
    assign err_nochange = enoch_q;
    assign change_left  = change_q;

    always_comb begin
        for (int i = 0; i < 4; i++) inv_empty[i] = (cnt_q[i] == '0);
    end

endmodule
